// File: rtl/arm_wb_pkg.sv
// Shared types for the write-back stage.
// Pending-load bundle, state encoding and register-bit helper.
package arm_wb_pkg;

  typedef enum logic {
    WB_IDLE,
    WB_WAIT_LOAD
  } wb_state_t;

  localparam logic [3:0] REG_PC = 4'd15;

  typedef struct packed {
    logic [3:0] rd;
    logic       reg_write;
    logic       ld_byte;
    logic [1:0] addr_lo;
  } wb_pending_t;

  // One-hot busy bit for a register write; the PC never gets one.
  function automatic logic [15:0] reg_bit(
    input logic [3:0] rd,
    input logic       en
  );
    logic [15:0] m;
    m = '0;
    if (en && rd != REG_PC) m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment for the write-back stage.
// Word loads pass through; byte loads select and zero-extend.
module load_align (
  input  logic [31:0] rdata,
  input  logic        ld_byte,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0] sel;

  always_comb begin
    sel = '0;
    unique case (addr_lo)
      2'd0: sel = rdata[7:0];
      2'd1: sel = rdata[15:8];
      2'd2: sel = rdata[23:16];
      2'd3: sel = rdata[31:24];
    endcase
  end

  assign data = ld_byte ? {24'b0, sel} : rdata;

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: commits results to the register file,
// waits for load data with timeout, redirects PC on rd==15.
module writeback_unit
  import arm_wb_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 64,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_reg_write,
  input  logic [3:0]        ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_ld_byte,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ld_rvalid,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic              RegWrite,
  output logic [3:0]        a3,
  output logic [DATA_W-1:0] wd3,
  output logic              pc_wr_en,
  output logic [DATA_W-1:0] pc_wr_data,
  output logic [15:0]       busy_mask,
  output logic              retire,
  output logic              ld_error
);

  localparam logic [7:0] CNT_LAST = 8'(LOAD_TIMEOUT - 1);

  wb_state_t   state, state_n;
  logic [7:0]  cnt, cnt_n;
  wb_pending_t pend, pend_n;
  logic [15:0] clr_q, clr_n;

  logic              accept;
  logic              done;
  logic              timeout;
  logic [3:0]        done_rd;
  logic              done_we;
  logic [DATA_W-1:0] done_data;
  logic [DATA_W-1:0] ld_data;
  logic              wr_rf;
  logic              wr_pc;
  logic [15:0]       set_mask;
  logic [15:0]       clr_mask;

  load_align u_align (
    .rdata   (ld_rdata),
    .ld_byte (pend.ld_byte),
    .addr_lo (pend.addr_lo),
    .data    (ld_data)
  );

  assign ex_ready = (state == WB_IDLE);
  assign accept   = ex_valid && ex_ready;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pend_n    = pend;
    done      = 1'b0;
    timeout   = 1'b0;
    done_rd   = ex_rd;
    done_we   = ex_reg_write;
    done_data = ex_result;
    unique case (state)
      WB_IDLE: begin
        if (accept && ex_is_load) begin
          state_n        = WB_WAIT_LOAD;
          cnt_n          = '0;
          pend_n.rd        = ex_rd;
          pend_n.reg_write = ex_reg_write;
          pend_n.ld_byte   = ex_ld_byte;
          pend_n.addr_lo   = ex_result[1:0];
        end else if (accept) begin
          done = 1'b1;
        end
      end
      WB_WAIT_LOAD: begin
        cnt_n = cnt + 8'd1;
        if (ld_rvalid) begin
          done      = 1'b1;
          done_rd   = pend.rd;
          done_we   = pend.reg_write;
          done_data = ld_data;
          state_n   = WB_IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout = 1'b1;
          state_n = WB_IDLE;
        end
      end
    endcase
  end

  assign wr_rf = done && done_we && (done_rd != REG_PC);
  assign wr_pc = done && done_we && (done_rd == REG_PC);

  // Busy bits set at acceptance; a same-edge set overrides a clear.
  assign set_mask = accept ? reg_bit(ex_rd, ex_reg_write) : '0;
  assign clr_mask = clr_q
                  | (timeout ? reg_bit(pend.rd, pend.reg_write) : '0);
  assign clr_n    = done ? reg_bit(done_rd, done_we) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WB_IDLE;
      cnt        <= '0;
      pend       <= '0;
      clr_q      <= '0;
      busy_mask  <= '0;
      RegWrite   <= 1'b0;
      a3         <= '0;
      wd3        <= '0;
      pc_wr_en   <= 1'b0;
      pc_wr_data <= '0;
      retire     <= 1'b0;
      ld_error   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pend      <= pend_n;
      clr_q     <= clr_n;
      busy_mask <= (busy_mask & ~clr_mask) | set_mask;
      RegWrite  <= wr_rf;
      pc_wr_en  <= wr_pc;
      retire    <= done;
      ld_error  <= timeout;
      if (wr_rf) begin
        a3  <= done_rd;
        wd3 <= done_data;
      end
      if (wr_pc) begin
        pc_wr_data <= {done_data[DATA_W-1:2], 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed testbench for writeback_unit.
// Scenario tasks with hand-computed expectations.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_reg_write;
  logic [3:0]  ex_rd;
  logic        ex_is_load;
  logic        ex_ld_byte;
  logic [31:0] ex_result;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        RegWrite;
  logic [3:0]  a3;
  logic [31:0] wd3;
  logic        pc_wr_en;
  logic [31:0] pc_wr_data;
  logic [15:0] busy_mask;
  logic        retire;
  logic        ld_error;

  int checks = 0;
  int errors = 0;

  writeback_unit #(.LOAD_TIMEOUT(8), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_reg_write (ex_reg_write),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_ld_byte   (ex_ld_byte),
    .ex_result    (ex_result),
    .ld_rvalid    (ld_rvalid),
    .ld_rdata     (ld_rdata),
    .RegWrite     (RegWrite),
    .a3           (a3),
    .wd3          (wd3),
    .pc_wr_en     (pc_wr_en),
    .pc_wr_data   (pc_wr_data),
    .busy_mask    (busy_mask),
    .retire       (retire),
    .ld_error     (ld_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [3:0] rd,
                       input logic ld, input logic lb, input logic [31:0] res);
    ex_valid     = v;
    ex_reg_write = we;
    ex_rd        = rd;
    ex_is_load   = ld;
    ex_ld_byte   = lb;
    ex_result    = res;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_in();
    ld_rvalid = 1'b0;
    ld_rdata  = '0;
    step();
    step();
    reset = 1'b0;
    checks++;
    if ({ex_ready, RegWrite, pc_wr_en, retire, ld_error} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 10000",
               {ex_ready, RegWrite, pc_wr_en, retire, ld_error});
    end
    checks++;
    if ({busy_mask, a3, wd3, pc_wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: busy=%h a3=%h wd3=%h pc=%h want 0",
               busy_mask, a3, wd3, pc_wr_data);
    end
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 32'hDEADBEEF);
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL alu_ready: got %b want 1", ex_ready);
    end
    step();
    idle_in();
    checks++;
    if ({RegWrite, retire, a3, wd3, busy_mask} !== {1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 16'h0008}) begin
      errors++;
      $display("FAIL alu_commit: we=%b ret=%b a3=%h wd3=%h busy=%h want 1 1 3 deadbeef 0008",
               RegWrite, retire, a3, wd3, busy_mask);
    end
    step();
    checks++;
    if ({RegWrite, retire, busy_mask} !== {1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL alu_after: we=%b ret=%b busy=%h want 0 0 0000", RegWrite, retire, busy_mask);
    end
    step();
    checks++;
    if (busy_mask !== 16'h0) begin
      errors++;
      $display("FAIL alu_busy_n2: got %h want 0000", busy_mask);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  rds [3];
    logic [31:0] vals[3];
    logic [15:0] bm  [3];
    rds  = '{4'd1, 4'd2, 4'd1};
    vals = '{32'h111, 32'h222, 32'h333};
    bm   = '{16'h0002, 16'h0004, 16'h0002};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, rds[i], 1'b0, 1'b0, vals[i]);
      checks++;
      if (ex_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready%0d: got %b want 1", i, ex_ready);
      end
      step();
      checks++;
      if ({RegWrite, a3, wd3, busy_mask} !== {1'b1, rds[i], vals[i], bm[i]}) begin
        errors++;
        $display("FAIL b2b_commit%0d: we=%b a3=%h wd3=%h busy=%h want 1 %h %h %h",
                 i, RegWrite, a3, wd3, busy_mask, rds[i], vals[i], bm[i]);
      end
    end
    idle_in();
    step();
    checks++;
    if ({RegWrite, busy_mask} !== {1'b0, 16'h0}) begin
      errors++;
      $display("FAIL b2b_drain: we=%b busy=%h want 0 0000", RegWrite, busy_mask);
    end
  endtask

  task automatic test_set_wins();
    drive(1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 32'h4);
    step();
    drive(1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 32'h44);
    step();
    idle_in();
    checks++;
    if (busy_mask !== 16'h0010) begin
      errors++;
      $display("FAIL set_wins: busy=%h want 0010", busy_mask);
    end
    step();
    checks++;
    if (busy_mask !== 16'h0) begin
      errors++;
      $display("FAIL set_wins_clr: busy=%h want 0000", busy_mask);
    end
  endtask

  task automatic test_ldrb();
    drive(1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 32'h1002);
    step();
    idle_in();
    checks++;
    if ({ex_ready, RegWrite, retire, busy_mask} !== {1'b0, 1'b0, 1'b0, 16'h0020}) begin
      errors++;
      $display("FAIL ldrb_wait: rdy=%b we=%b ret=%b busy=%h want 0 0 0 0020",
               ex_ready, RegWrite, retire, busy_mask);
    end
    for (int k = 1; k < 4; k++) begin
      step();
      checks++;
      if ({ex_ready, RegWrite} !== 2'b00) begin
        errors++;
        $display("FAIL ldrb_wait%0d: rdy=%b we=%b want 0 0", k, ex_ready, RegWrite);
      end
    end
    ld_rvalid = 1'b1;
    ld_rdata  = 32'h11AA2233;
    step();
    ld_rvalid = 1'b0;
    ld_rdata  = 32'hFFFFFFFF;
    checks++;
    if ({ex_ready, RegWrite, retire, a3, wd3} !== {1'b1, 1'b1, 1'b1, 4'd5, 32'h000000AA}) begin
      errors++;
      $display("FAIL ldrb_commit: rdy=%b we=%b ret=%b a3=%h wd3=%h want 1 1 1 5 000000aa",
               ex_ready, RegWrite, retire, a3, wd3);
    end
    step();
  endtask

  task automatic test_word_load();
    drive(1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 32'h2003);
    step();
    idle_in();
    ld_rvalid = 1'b1;
    ld_rdata  = 32'hCAFEF00D;
    step();
    ld_rvalid = 1'b0;
    checks++;
    if ({RegWrite, a3, wd3} !== {1'b1, 4'd6, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL word_load: we=%b a3=%h wd3=%h want 1 6 cafef00d", RegWrite, a3, wd3);
    end
    step();
  endtask

  task automatic test_pc_redirect();
    drive(1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 32'h00001007);
    step();
    idle_in();
    checks++;
    if ({RegWrite, pc_wr_en, retire, pc_wr_data, busy_mask} !==
        {1'b0, 1'b1, 1'b1, 32'h00001004, 16'h0}) begin
      errors++;
      $display("FAIL pc_redirect: we=%b pce=%b ret=%b pc=%h busy=%h want 0 1 1 00001004 0000",
               RegWrite, pc_wr_en, retire, pc_wr_data, busy_mask);
    end
    checks++;
    if ({a3, wd3} !== {4'd6, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL pc_rf_hold: a3=%h wd3=%h want 6 cafef00d", a3, wd3);
    end
    step();
    checks++;
    if (pc_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL pc_pulse: pce=%b want 0", pc_wr_en);
    end
  endtask

  task automatic test_no_write();
    drive(1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 32'h12345678);
    step();
    idle_in();
    checks++;
    if ({retire, RegWrite, pc_wr_en, a3, wd3, busy_mask} !==
        {1'b1, 1'b0, 1'b0, 4'd6, 32'hCAFEF00D, 16'h0}) begin
      errors++;
      $display("FAIL no_write: ret=%b we=%b pce=%b a3=%h wd3=%h busy=%h want 1 0 0 6 cafef00d 0000",
               retire, RegWrite, pc_wr_en, a3, wd3, busy_mask);
    end
    step();
  endtask

  task automatic test_timeout();
    drive(1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 32'h3000);
    step();
    idle_in();
    checks++;
    if (busy_mask !== 16'h0080) begin
      errors++;
      $display("FAIL to_busy: got %h want 0080", busy_mask);
    end
    for (int k = 1; k < 8; k++) begin
      step();
      checks++;
      if ({ex_ready, ld_error} !== 2'b00) begin
        errors++;
        $display("FAIL to_wait%0d: rdy=%b err=%b want 0 0", k, ex_ready, ld_error);
      end
    end
    step();
    checks++;
    if ({ld_error, ex_ready, RegWrite, retire, busy_mask} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL to_fire: err=%b rdy=%b we=%b ret=%b busy=%h want 1 1 0 0 0000",
               ld_error, ex_ready, RegWrite, retire, busy_mask);
    end
    ld_rvalid = 1'b1;
    ld_rdata  = 32'h55555555;
    step();
    ld_rvalid = 1'b0;
    checks++;
    if ({ld_error, RegWrite, retire, wd3} !== {1'b0, 1'b0, 1'b0, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL to_late: err=%b we=%b ret=%b wd3=%h want 0 0 0 cafef00d",
               ld_error, RegWrite, retire, wd3);
    end
  endtask

  task automatic test_rvalid_at_timeout();
    drive(1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 32'h4000);
    step();
    idle_in();
    for (int k = 1; k < 8; k++) step();
    ld_rvalid = 1'b1;
    ld_rdata  = 32'h0BADCAFE;
    step();
    ld_rvalid = 1'b0;
    checks++;
    if ({ld_error, RegWrite, a3, wd3} !== {1'b0, 1'b1, 4'd8, 32'h0BADCAFE}) begin
      errors++;
      $display("FAIL to_edge: err=%b we=%b a3=%h wd3=%h want 0 1 8 0badcafe",
               ld_error, RegWrite, a3, wd3);
    end
    step();
  endtask

  task automatic test_reset_in_load();
    drive(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 32'h5000);
    step();
    idle_in();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({ex_ready, RegWrite, ld_error, busy_mask} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL rst_load: rdy=%b we=%b err=%b busy=%h want 1 0 0 0000",
               ex_ready, RegWrite, ld_error, busy_mask);
    end
    ld_rvalid = 1'b1;
    ld_rdata  = 32'h77777777;
    step();
    ld_rvalid = 1'b0;
    checks++;
    if ({RegWrite, retire, ld_error, busy_mask} !== {1'b0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL rst_late: we=%b ret=%b err=%b busy=%h want 0 0 0 0000",
               RegWrite, retire, ld_error, busy_mask);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_set_wins();
    test_ldrb();
    test_word_load();
    test_pc_redirect();
    test_no_write();
    test_timeout();
    test_rvalid_at_timeout();
    test_reset_in_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
